// File: rtl/stepper_axis_driver_if.sv
// stepper_axis_driver_if
//   Bundles the command inputs and drive/status outputs of one stepper axis.
//   master : command source (movement controller or test bench)
//   slave  : the axis driver
//   Signals:
//     dir_cmd    [1:0]  00 stop, 01 CW (+), 10 CCW (-), 11 stop
//     enable            0 forces stop behaviour
//     half_step         1 = 8-phase half-step, 0 = 4-phase full-step
//     coils      [3:0]  coil drive {A,B,C,D}
//     position   [15:0] signed step count
//     step_pulse        one clk high in the cycle after a step is applied
//     at_min, at_max    position at the soft limits
//     energised         coils are being driven
interface stepper_axis_driver_if;
  logic [1:0]         dir_cmd;
  logic               enable;
  logic               half_step;
  logic [3:0]         coils;
  logic signed [15:0] position;
  logic               step_pulse;
  logic               at_min;
  logic               at_max;
  logic               energised;

  modport master (
    output dir_cmd, enable, half_step,
    input  coils, position, step_pulse, at_min, at_max, energised
  );

  modport slave (
    input  dir_cmd, enable, half_step,
    output coils, position, step_pulse, at_min, at_max, energised
  );
endinterface

// File: rtl/stepper_axis_driver.sv
// stepper_axis_driver
//   Converts a 2-bit direction code into a timed 4-coil unipolar stepper
//   phase sequence for one tracker axis, tracks a signed position with soft
//   limits and releases the coils after an idle period.
//   Ports:
//     clk   system clock
//     rst   synchronous active-high reset
//     axis  stepper_axis_driver_if.slave (commands in, coil drive/status out)
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | coils released (0000), waiting for a request on a tick
//   HOLD  | coils energised on table[idx], not stepping, idle timer runs
//   MOVE  | stepping one phase per tick in last_dir
module stepper_axis_driver #(
  parameter int CLK_DIV    = 50000,
  parameter int HOLD_TICKS = 16,
  parameter int POS_MIN    = -1000,
  parameter int POS_MAX    = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  stepper_axis_driver_if.slave  axis
);

  localparam int CNT_W  = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int IDLE_W = $clog2(HOLD_TICKS + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(HOLD_TICKS - 1);
  localparam logic signed [15:0] P_MIN = 16'(POS_MIN);
  localparam logic signed [15:0] P_MAX = 16'(POS_MAX);

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_MOVE} state_t;
  typedef enum logic [1:0] {DIR_NONE, DIR_CW, DIR_CCW} dir_t;

  state_t             state, state_n;
  dir_t               last_dir, last_dir_n;
  logic [CNT_W-1:0]   cnt;
  logic [IDLE_W-1:0]  idle_cnt, idle_cnt_n;
  logic [2:0]         idx, idx_n;
  logic signed [15:0] position, position_n;
  logic [3:0]         coils, coils_n;
  logic               step_pulse;
  logic               tick;
  logic               do_step;
  logic               req_cw, req_ccw, req, blocked, reversal;
  dir_t               req_dir;

  function automatic logic [3:0] phase(input logic [2:0] i);
    logic [3:0] p;
    case (i)
      3'd0:    p = 4'b1000;
      3'd1:    p = 4'b1100;
      3'd2:    p = 4'b0100;
      3'd3:    p = 4'b0110;
      3'd4:    p = 4'b0010;
      3'd5:    p = 4'b0011;
      3'd6:    p = 4'b0001;
      default: p = 4'b1001;
    endcase
    return p;
  endfunction

  // Full-step lands on odd entries (two coils on); an extra nudge in the
  // travel direction realigns an even index left over from half-stepping.
  function automatic logic [2:0] advance(input logic [2:0] i, input logic cw,
                                         input logic half);
    logic [2:0] t;
    if (half) begin
      t = cw ? i + 3'd1 : i - 3'd1;
    end else begin
      t = cw ? i + 3'd2 : i - 3'd2;
      if (!t[0]) t = cw ? t + 3'd1 : t - 3'd1;
    end
    return t;
  endfunction

  assign tick     = (cnt == CNT_LAST);
  assign req_cw   = axis.enable && (axis.dir_cmd == 2'b01);
  assign req_ccw  = axis.enable && (axis.dir_cmd == 2'b10);
  assign req      = req_cw || req_ccw;
  assign req_dir  = req_cw ? DIR_CW : DIR_CCW;
  assign blocked  = (req_cw && position == P_MAX) || (req_ccw && position == P_MIN);
  assign reversal = req && (last_dir != DIR_NONE) && (req_dir != last_dir);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      state      <= S_IDLE;
      last_dir   <= DIR_NONE;
      idle_cnt   <= '0;
      idx        <= 3'd0;
      position   <= 16'sd0;
      coils      <= 4'b0000;
      step_pulse <= 1'b0;
    end else begin
      cnt        <= tick ? '0 : cnt + CNT_W'(1);
      state      <= state_n;
      last_dir   <= last_dir_n;
      idle_cnt   <= idle_cnt_n;
      idx        <= idx_n;
      position   <= position_n;
      coils      <= coils_n;
      step_pulse <= do_step;
    end
  end

  always_comb begin
    state_n    = state;
    last_dir_n = last_dir;
    idle_cnt_n = idle_cnt;
    idx_n      = idx;
    position_n = position;
    do_step    = 1'b0;

    if (tick) begin
      case (state)
        S_IDLE: begin
          if (req) begin
            state_n    = S_HOLD;
            idle_cnt_n = '0;
          end
        end
        S_HOLD: begin
          if (reversal) begin
            last_dir_n = DIR_NONE;
          end else if (req && !blocked) begin
            state_n = S_MOVE;
            do_step = 1'b1;
          end else if (idle_cnt == IDLE_LAST) begin
            state_n    = S_IDLE;
            idle_cnt_n = '0;
          end else begin
            idle_cnt_n = idle_cnt + IDLE_W'(1);
          end
        end
        S_MOVE: begin
          if (reversal) begin
            state_n    = S_HOLD;
            last_dir_n = DIR_NONE;
          end else if (req && !blocked) begin
            do_step = 1'b1;
          end else begin
            state_n = S_HOLD;
          end
        end
        default: state_n = S_IDLE;
      endcase

      if (do_step) begin
        idx_n      = advance(idx, req_cw, axis.half_step);
        position_n = req_cw ? position + 16'sd1 : position - 16'sd1;
        last_dir_n = req_dir;
        idle_cnt_n = '0;
      end
    end

    coils_n = (state_n == S_IDLE) ? 4'b0000 : phase(idx_n);
  end

  assign axis.coils      = coils;
  assign axis.position   = position;
  assign axis.step_pulse = step_pulse;
  assign axis.at_min     = (position == P_MIN);
  assign axis.at_max     = (position == P_MAX);
  assign axis.energised  = (state != S_IDLE);

endmodule

// File: tb/tb_stepper_axis_driver.sv
// Scoreboard bench for stepper_axis_driver (CLK_DIV=4, HOLD_TICKS=3,
// POS_MIN=-2, POS_MAX=3). Stimulus pushes hand-computed expectations for each
// tick and each reset; the monitor pops and compares on the cycle after.
module tb_stepper_axis_driver;
  logic clk = 1'b0;
  logic rst = 1'b1;

  stepper_axis_driver_if bus ();

  stepper_axis_driver #(
    .CLK_DIV(4), .HOLD_TICKS(3), .POS_MIN(-2), .POS_MAX(3)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .axis (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string              name;
    logic [3:0]         coils;
    logic signed [15:0] pos;
    logic               pulse;
    logic               energ;
    logic               at_min;
    logic               at_max;
  } chk_t;

  chk_t q[$];
  chk_t cur;
  int   tests = 0;
  int   fails = 0;
  int   tb_cnt = 0;
  logic post_tick = 1'b0;
  logic post_rst  = 1'b0;

  // Reference tick timing: prescaler free-runs from reset.
  always @(posedge clk) begin
    if (rst) tb_cnt <= 0;
    else     tb_cnt <= (tb_cnt == 3) ? 0 : tb_cnt + 1;
    post_tick <= !rst && (tb_cnt == 3);
    post_rst  <= rst;
  end

  always @(negedge clk) begin
    if ((post_tick || post_rst) && q.size() > 0) begin
      cur = q.pop_front();
      tests++;
      if (bus.coils !== cur.coils || bus.position !== cur.pos ||
          bus.step_pulse !== cur.pulse || bus.energised !== cur.energ ||
          bus.at_min !== cur.at_min || bus.at_max !== cur.at_max) begin
        fails++;
        $display("FAIL %s: got coils=%b pos=%0d pulse=%b energised=%b min=%b max=%b, expected coils=%b pos=%0d pulse=%b energised=%b min=%b max=%b",
                 cur.name, bus.coils, bus.position, bus.step_pulse, bus.energised,
                 bus.at_min, bus.at_max, cur.coils, cur.pos, cur.pulse, cur.energ,
                 cur.at_min, cur.at_max);
      end
    end
  end

  task automatic push(input string name, input logic [3:0] c, input int p,
                      input logic pulse, input logic energ);
    chk_t e;
    e.name   = name;
    e.coils  = c;
    e.pos    = 16'(p);
    e.pulse  = pulse;
    e.energ  = energ;
    e.at_min = (p == -2);
    e.at_max = (p == 3);
    q.push_back(e);
  endtask

  // Called at a negedge; applies inputs, waits for the tick cycle, records the
  // expectation and returns at the negedge after the tick edge.
  task automatic do_tick(input string name, input logic [1:0] d, input logic en,
                         input logic hs, input logic [3:0] c, input int p,
                         input logic pulse, input logic energ);
    bus.dir_cmd   = d;
    bus.enable    = en;
    bus.half_step = hs;
    while (tb_cnt != 3) @(negedge clk);
    push(name, c, p, pulse, energ);
    @(negedge clk);
  endtask

  task automatic do_reset(input string name);
    rst = 1'b1;
    push(name, 4'b0000, 0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.dir_cmd   = 2'b00;
    bus.enable    = 1'b0;
    bus.half_step = 1'b0;
    push("reset_state", 4'b0000, 0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Half-step CW up to the upper limit, then release after hold timeout.
    do_tick("hs_reenergise", 2'b01, 1, 1, 4'b1000, 0, 0, 1);
    do_tick("hs_step1",      2'b01, 1, 1, 4'b1100, 1, 1, 1);
    do_tick("hs_step2",      2'b01, 1, 1, 4'b0100, 2, 1, 1);
    do_tick("hs_step3",      2'b01, 1, 1, 4'b0110, 3, 1, 1);
    do_tick("max_block",     2'b01, 1, 1, 4'b0110, 3, 0, 1);
    do_tick("max_hold1",     2'b01, 1, 1, 4'b0110, 3, 0, 1);
    do_tick("max_hold2",     2'b01, 1, 1, 4'b0110, 3, 0, 1);
    do_tick("max_release",   2'b01, 1, 1, 4'b0000, 3, 0, 0);

    // Reverse: re-energise, one dead tick, then CCW half-steps.
    do_tick("rev_reenergise", 2'b10, 1, 1, 4'b0110, 3, 0, 1);
    do_tick("rev_dead",       2'b10, 1, 1, 4'b0110, 3, 0, 1);
    do_tick("ccw1",           2'b10, 1, 1, 4'b0100, 2, 1, 1);
    do_tick("ccw2",           2'b10, 1, 1, 4'b1100, 1, 1, 1);
    do_tick("ccw3",           2'b10, 1, 1, 4'b1000, 0, 1, 1);
    do_tick("ccw4",           2'b10, 1, 1, 4'b1001, -1, 1, 1);
    do_tick("enable_off",     2'b10, 0, 1, 4'b1001, -1, 0, 1);
    do_reset("reset_between");

    // Full-step CW from idx 0 lands on odd entries.
    do_tick("fs_reenergise", 2'b01, 1, 0, 4'b1000, 0, 0, 1);
    do_tick("fs_step1",      2'b01, 1, 0, 4'b0110, 1, 1, 1);
    do_tick("fs_step2",      2'b01, 1, 0, 4'b0011, 2, 1, 1);
    do_tick("fs_step3",      2'b01, 1, 0, 4'b1001, 3, 1, 1);
    do_tick("fs_max_block",  2'b01, 1, 0, 4'b1001, 3, 0, 1);

    // Full-step CCW down to the lower limit.
    do_tick("fs_rev_dead",  2'b10, 1, 0, 4'b1001, 3, 0, 1);
    do_tick("fs_ccw1",      2'b10, 1, 0, 4'b0011, 2, 1, 1);
    do_tick("fs_ccw2",      2'b10, 1, 0, 4'b0110, 1, 1, 1);
    do_tick("fs_ccw3",      2'b10, 1, 0, 4'b1100, 0, 1, 1);
    do_tick("fs_ccw4",      2'b10, 1, 0, 4'b1001, -1, 1, 1);
    do_tick("fs_ccw5",      2'b10, 1, 0, 4'b0011, -2, 1, 1);
    do_tick("min_block",    2'b10, 1, 0, 4'b0011, -2, 0, 1);
    do_tick("min_hold",     2'b10, 1, 0, 4'b0011, -2, 0, 1);
    do_tick("min_rev_dead", 2'b01, 1, 0, 4'b0011, -2, 0, 1);
    do_tick("min_cw",       2'b01, 1, 0, 4'b1001, -1, 1, 1);

    // Mode changes take effect at the next step; full-step realigns to odd.
    do_tick("hs_switch",  2'b01, 1, 1, 4'b1000, 0, 1, 1);
    do_tick("fs_realign", 2'b01, 1, 0, 4'b0110, 1, 1, 1);
    do_reset("reset_clean");

    // Reset while moving at position 2.
    do_tick("mm_reenergise", 2'b01, 1, 1, 4'b1000, 0, 0, 1);
    do_tick("mm_step1",      2'b01, 1, 1, 4'b1100, 1, 1, 1);
    do_tick("mm_step2",      2'b01, 1, 1, 4'b0100, 2, 1, 1);
    do_reset("reset_mid_move");

    // A request pulse that lands only between ticks is ignored.
    bus.dir_cmd   = 2'b01;
    bus.enable    = 1'b1;
    bus.half_step = 1'b1;
    while (tb_cnt != 0) @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    do_tick("toggle_ignored", 2'b00, 1, 1, 4'b0000, 0, 0, 0);
    do_tick("toggle_after",   2'b01, 1, 1, 4'b1000, 0, 0, 1);

    bus.dir_cmd = 2'b00;
    repeat (8) @(negedge clk);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
